// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 receive types and scan-code constants.
// Used by ps2_rx and the downstream keyboard-entry FSMs.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  localparam int FRAME_DATA_BITS = 8;

  localparam logic [7:0] RELEASE  = 8'hF0;
  localparam logic [7:0] EXTENDED = 8'hE0;

  function automatic logic odd_ok(
    input logic [FRAME_DATA_BITS-1:0] b,
    input logic                       p
  );
    return ^{b, p};
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: pin synchroniser and PS2_CLK falling-edge detector.
// Optional clock deglitch filter: define PS2_RX_DEGLITCH_EN.
module ps2_sync_edge #(
  parameter int FILTER_LEN = 8
) (
  input  logic Clock,
  input  logic Reset,
  input  logic ps2_clk,
  input  logic ps2_dat,
  output logic clk_fall,
  output logic dat_sync
);

  logic [1:0] clk_s;
  logic [1:0] dat_s;
  logic       lvl;
  logic       lvl_q;
  logic       dat_lvl;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      clk_s <= '1;
      dat_s <= '1;
    end else begin
      clk_s <= {clk_s[0], ps2_clk};
      dat_s <= {dat_s[0], ps2_dat};
    end
  end

`ifdef PS2_RX_DEGLITCH_EN
  localparam int FW = $clog2(FILTER_LEN + 1);

  logic [FW-1:0]         fcnt;
  logic [FILTER_LEN-1:0] dat_dly;

  // DAT is delayed by the same FILTER_LEN cycles the filter adds to CLK
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      lvl     <= 1'b1;
      fcnt    <= '0;
      dat_dly <= '1;
    end else begin
      dat_dly <= (dat_dly << 1) | FILTER_LEN'(dat_s[1]);
      if (clk_s[1] == lvl) begin
        fcnt <= '0;
      end else if (fcnt == FW'(FILTER_LEN - 1)) begin
        lvl  <= clk_s[1];
        fcnt <= '0;
      end else begin
        fcnt <= fcnt + FW'(1);
      end
    end
  end

  assign dat_lvl = dat_dly[FILTER_LEN-1];
`else
  assign lvl     = clk_s[1];
  assign dat_lvl = dat_s[1];

  if (FILTER_LEN < 1) begin : g_bad_filter_len
  end
`endif

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) lvl_q <= 1'b1;
    else       lvl_q <= lvl;
  end

  assign clk_fall = lvl_q & ~lvl;
  assign dat_sync = dat_lvl;

endmodule

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host frame receiver with parity/frame checks.
// Optional PS2_CLK deglitch filter: define PS2_RX_DEGLITCH_EN.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] data,
  output logic       data_en,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int CW = $clog2(FRAME_DATA_BITS);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] C_LAST = CW'(FRAME_DATA_BITS - 1);

  logic fall;
  logic dat;

  ps2_sync_edge #(
    .FILTER_LEN(FILTER_LEN)
  ) u_sync (
    .Clock   (Clock),
    .Reset   (Reset),
    .ps2_clk (PS2_CLK),
    .ps2_dat (PS2_DAT),
    .clk_fall(fall),
    .dat_sync(dat)
  );

  ps2_state_t                 state, state_n;
  logic [CW-1:0]              bit_cnt, bit_cnt_n;
  logic [FRAME_DATA_BITS-1:0] shreg, shreg_n;
  logic                       par, par_n;
  logic [TW-1:0]              tcnt, tcnt_n;
  logic [7:0]                 data_n;
  logic                       data_en_n;
  logic                       perr_n;
  logic                       ferr_n;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par        <= 1'b0;
      tcnt       <= '0;
      data       <= '0;
      data_en    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      shreg      <= shreg_n;
      par        <= par_n;
      tcnt       <= tcnt_n;
      data       <= data_n;
      data_en    <= data_en_n;
      parity_err <= perr_n;
      frame_err  <= ferr_n;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    par_n     = par;
    tcnt_n    = (state == IDLE) ? '0 : tcnt + TW'(1);
    data_n    = data;
    data_en_n = 1'b0;
    perr_n    = 1'b0;
    ferr_n    = 1'b0;
    // an edge always beats a simultaneous timeout
    if (fall) begin
      tcnt_n = '0;
      unique case (state)
        IDLE: begin
          if (!dat) begin
            state_n   = DATA;
            bit_cnt_n = '0;
          end
        end
        DATA: begin
          shreg_n   = {dat, shreg[FRAME_DATA_BITS-1:1]};
          bit_cnt_n = bit_cnt + CW'(1);
          if (bit_cnt == C_LAST) state_n = PARITY;
        end
        PARITY: begin
          par_n   = dat;
          state_n = STOP;
        end
        STOP: begin
          state_n = IDLE;
          if (!dat) begin
            ferr_n = 1'b1;
          end else if (odd_ok(shreg, par)) begin
            data_n    = shreg;
            data_en_n = 1'b1;
          end else begin
            perr_n = 1'b1;
          end
        end
      endcase
    end else if (state != IDLE && tcnt == T_LAST) begin
      state_n = IDLE;
      tcnt_n  = '0;
      ferr_n  = 1'b1;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: doc/ps2_rx.md
Name: ps2_rx

Overview:
PS/2 device-to-host serial receiver, directly upstream of the keyboard-entry FSMs.
- Synchronises the raw PS2_CLK/PS2_DAT pins and deframes 11-bit frames.
- Emits each valid scan-code byte (make, 0xF0 release, 0xE0 extended) as `data` plus a one-cycle `data_en` strobe.
- Bad frames are dropped and flagged; downstream only ever sees clean bytes.

Parameters:
- TIMEOUT_CYCLES, 10000, Clock cycles allowed between PS/2 falling edges inside a frame before abort (200 us at 50 MHz).
- FILTER_LEN, 8, Consecutive equal samples needed to accept a PS2_CLK level change. Used only with the deglitch feature.

Ports:
- Clock  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- PS2_CLK  in  1  raw PS/2 clock pin, idle high
- PS2_DAT  in  1  raw PS/2 data pin, idle high
- data  out  8  last valid received byte
- data_en  out  1  one-cycle strobe: `data` newly valid
- parity_err  out  1  one-cycle pulse: frame dropped, odd parity failed
- frame_err  out  1  one-cycle pulse: frame dropped, bad start/stop bit or timeout
- busy  out  1  high while a frame is in progress (state != IDLE)

Behaviour:
Reset values:
- Reset is asynchronous, active-high.
- data=0x00, data_en=0, parity_err=0, frame_err=0, busy=0.
- Synchroniser flops = 1. State = IDLE, bit counter = 0, timeout counter = 0.

Input conditioning:
- Each pin passes through a 2-flop synchroniser.
- A registered falling-edge detector on synced PS2_CLK produces `fall`, a one-cycle pulse.
- Synced DAT is sampled in the `fall` cycle.

Frame format:
- start 0, then d0..d7 LSB first, then odd parity bit, then stop 1.

States:
- IDLE: on `fall`, DAT=0 -> DATA (bit counter=0). DAT=1 -> stay in IDLE, no error.
- DATA: on each `fall`, shift DAT in at MSB (shift right) and increment the counter. After the 8th bit -> PARITY.
- PARITY: on `fall`, latch the parity bit -> STOP.
- STOP: on `fall`:
  - stop=1 and XOR(d7..d0, parity)=1: data<=byte, data_en=1 for one cycle.
  - stop=1 and parity wrong: parity_err pulse, `data` holds its old value.
  - stop=0: frame_err pulse; takes priority over parity_err. `data` holds.
  - Always return to IDLE.

Latency:
- Outputs register in the `fall` cycle of the stop bit. data_en/err pulses are high the cycle after that `fall` (E+1), for exactly one cycle.

Timeout:
- The counter runs while state != IDLE and clears on every `fall`.
- When it reaches TIMEOUT_CYCLES-1: return to IDLE, frame_err pulse, partial byte discarded.
- The counter is sized by $clog2(TIMEOUT_CYCLES).

Boundaries and simultaneous events:
- Back-to-back frames need no idle gap. IDLE accepts a start bit on the first `fall` after STOP.
- Timeout expiry and `fall` in the same cycle: `fall` wins, counter clears.
- Reset mid-frame: immediate return to reset values; no pulse emitted. The next frame is received normally.
- The block performs no make/break decoding; 0xF0 and 0xE0 are passed through as ordinary bytes.

Optional Feature:
Macro PS2_RX_DEGLITCH_EN.
- Defined: synced PS2_CLK feeds a counter filter. The filtered level changes only after FILTER_LEN consecutive samples differing from the current filtered level. `fall` derives from the filtered level. This adds FILTER_LEN cycles of latency; DAT sampling is delayed equally by an aligned delay line.
- Undefined: `fall` comes straight from the 2-flop synchroniser; FILTER_LEN is unused.

Decomposition:
- Package ps2_pkg:
  - state enum (IDLE, DATA, PARITY, STOP)
  - FRAME_DATA_BITS=8
  - scan constants RELEASE=8'hF0, EXTENDED=8'hE0, shared with the downstream FSMs
- Sub-module ps2_sync_edge: synchroniser, optional deglitch filter, falling-edge detector. Outputs clk_fall and dat_sync.

Test Plan:
- Frame 0x16 (parity 0, stop 1) at 12.5 kHz -> data=0x16, one-cycle data_en, no err pulses, busy low after stop.
- Back-to-back frames 0xF0 (parity 1) then 0x1E (parity 1) -> two data_en strobes, with data 0xF0 then 0x1E.
- Frame 0x16 with parity bit 1 -> parity_err pulse, no data_en, data keeps the previous value.
- Frame 0x16 with stop bit 0 -> frame_err pulse only. Next good frame 0x45 -> data=0x45.
- Start plus 5 data bits, then PS2_CLK held high for TIMEOUT_CYCLES -> frame_err pulse, busy=0. Following frame 0x24 is received correctly.
- Reset asserted mid-DATA -> all outputs at reset values with no pulse; with PS2_RX_DEGLITCH_EN, a 3-cycle PS2_CLK low glitch causes no bit shift.
